child_initiator: RTL and testbench

Initiator end of the child x/y handshake. It raises `probe_x` for a fixed pulse, waits for the responder (a `child` instance, which sets `child_y` on the rising edge of `child_x`) to assert `probe_y`, and reports the round-trip latency, a timeout, or a stuck-high line. It sits beside the responder instances in `verilog_simple`-style top levels so the blackboxed children can be exercised from synchronous logic.

---
 rtl/child_pkg.sv | 18 +
 rtl/child_initiator_sync2.sv | 28 ++
 rtl/child_initiator.sv | 138 +++++++++++++
 tb/tb_child_initiator.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/child_pkg.sv
// child_pkg: shared types and defaults for the child x/y handshake blocks.
//   child_init_state_t   : initiator FSM state encoding
//   CHILD_PULSE_CYCLES   : default cycles probe_x is held high
//   CHILD_TIMEOUT_CYCLES : default cycles from probe_x rise until timeout
package child_pkg;

  localparam int CHILD_PULSE_CYCLES   = 4;
  localparam int CHILD_TIMEOUT_CYCLES = 200;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_PULSE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } child_init_state_t;

endpackage

// File: rtl/child_initiator_sync2.sv
// child_sync2: two-flop synchronizer for a child's asynchronous y pin.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears both flops
//   i_d   : asynchronous input
//   o_q   : synchronized output, two clk edges of delay
module child_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/child_initiator.sv
// child_initiator: initiator end of the child x/y handshake. Raises probe_x
// for PULSE_CYCLES, waits for the responder's y, and reports round-trip
// latency, a timeout, or a line already stuck high.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request one probe (only sampled in IDLE)
//   probe_x    : registered drive to the responder's x pin
//   probe_y    : responder's y pin (asynchronous)
//   busy       : high in every state but IDLE
//   done       : one-cycle completion pulse
//   ok / timed_out / stuck : sticky result flags of the last probe
//   latency    : counter value when y was seen (valid when ok)
module child_initiator
  import child_pkg::*;
#(
  parameter int PULSE_CYCLES   = CHILD_PULSE_CYCLES,
  parameter int TIMEOUT_CYCLES = CHILD_TIMEOUT_CYCLES,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             probe_x,
  input  logic             probe_y,
  output logic             busy,
  output logic             done,
  output logic             ok,
  output logic             timed_out,
  output logic             stuck,
  output logic [CNT_W-1:0] latency
);

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT    = CNT_W'(TIMEOUT_CYCLES);

  child_init_state_t r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_probe_x;
  logic              r_busy;
  logic              r_done;
  logic              r_ok;
  logic              r_timed_out;
  logic              r_stuck;
  logic [CNT_W-1:0]  r_latency;
  logic              w_y;

  child_sync2 u_sync_y (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (probe_y),
    .o_q   (w_y)
  );

  // The counter must reach TIMEOUT without wrapping, and the pulse must end
  // before the timeout can fire.
  always @(posedge clk) begin
    if (rst_n)
      assert (PULSE_CYCLES >= 1 && TIMEOUT_CYCLES > PULSE_CYCLES &&
              TIMEOUT_CYCLES < (1 << CNT_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_probe_x   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ok        <= 1'b0;
      r_timed_out <= 1'b0;
      r_stuck     <= 1'b0;
      r_latency   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_ok        <= 1'b0;
            r_timed_out <= 1'b0;
            r_stuck     <= 1'b0;
            r_latency   <= '0;
            r_busy      <= 1'b1;
            r_state     <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (w_y) begin
            r_stuck <= 1'b1;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_probe_x <= 1'b1;
            r_cnt     <= '0;
            r_state   <= ST_PULSE;
          end
        end
        ST_PULSE, ST_WAIT: begin
          // y is tested first so it wins a tie with the timeout.
          if (w_y) begin
            r_latency <= r_cnt;
            r_ok      <= 1'b1;
            r_probe_x <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= ST_DONE;
          end else if (r_cnt == TIMEOUT) begin
            r_timed_out <= 1'b1;
            r_probe_x   <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_state == ST_PULSE && r_cnt == PULSE_LAST) begin
              r_probe_x <= 1'b0;
              r_state   <= ST_WAIT;
            end
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_probe_x <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign probe_x   = r_probe_x;
  assign busy      = r_busy;
  assign done      = r_done;
  assign ok        = r_ok;
  assign timed_out = r_timed_out;
  assign stuck     = r_stuck;
  assign latency   = r_latency;

endmodule

// File: tb/tb_child_initiator.sv
// tb_child_initiator: directed bench for child_initiator with default
// parameters (PULSE_CYCLES=4, TIMEOUT_CYCLES=200, CNT_W=8). Inputs change on
// the falling edge; outputs are sampled on the falling edge. "nK" below is
// the falling edge after the K-th rising edge, where edge 0 samples start.
module tb_child_initiator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       probe_y;
  logic       probe_x;
  logic       busy;
  logic       done;
  logic       ok;
  logic       timed_out;
  logic       stuck;
  logic [7:0] latency;

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;
  int px_cnt      = 0;

  always #5 clk = ~clk;

  child_initiator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .probe_x   (probe_x),
    .probe_y   (probe_y),
    .busy      (busy),
    .done      (done),
    .ok        (ok),
    .timed_out (timed_out),
    .stuck     (stuck),
    .latency   (latency)
  );

  // Running tallies of done pulses and probe_x-high cycles.
  always @(negedge clk) begin
    if (done === 1'b1)    done_cnt++;
    if (probe_x === 1'b1) px_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for done; n is the number of falling edges consumed.
  task automatic wait_done(input string tag, input int lim, output int n);
    logic seen;
    seen = 1'b0;
    n    = 0;
    while (!seen && n < lim) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  // Responder answers on the first edge after probe_x rises: y changes after
  // edge 2, the synchronizer shows it at edge 5, where the counter is 3.
  task automatic fast_probe(input string tag);
    int n;
    int p0;
    p0    = px_cnt;
    start = 1'b1;
    @(negedge clk); start = 1'b0;                 // n0
    @(negedge clk);                               // n1
    check({tag, "_px_rise"}, 32'(probe_x), 32'd1);
    @(negedge clk); probe_y = 1'b1;               // n2
    wait_done(tag, 20, n);
    check({tag, "_done_cyc"}, n, 32'd3);          // done at n5
    check({tag, "_ok"}, 32'(ok), 32'd1);
    check({tag, "_latency"}, 32'(latency), 32'd3);
    check({tag, "_timed_out"}, 32'(timed_out), 32'd0);
    check({tag, "_stuck"}, 32'(stuck), 32'd0);
    @(negedge clk);
    check({tag, "_done_width"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_px_cycles"}, px_cnt - p0, 32'd4);
    probe_y = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    int p0;
    int d0;
    rst_n   = 1'b0;
    start   = 1'b0;
    probe_y = 1'b0;
    #12;
    check("rst_probe_x", 32'(probe_x), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ok", 32'(ok), 32'd0);
    check("rst_timed_out", 32'(timed_out), 32'd0);
    check("rst_stuck", 32'(stuck), 32'd0);
    check("rst_latency", 32'(latency), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: fast responder
    fast_probe("fast");

    // 2: no responder -> timeout at counter 200 (edge 202)
    p0    = px_cnt;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done("tmo", 400, n);
    check("tmo_done_cyc", n, 32'd202);
    check("tmo_timed_out", 32'(timed_out), 32'd1);
    check("tmo_ok", 32'(ok), 32'd0);
    check("tmo_busy_in_done", 32'(busy), 32'd1);
    check("tmo_px_cycles", px_cnt - p0, 32'd4);
    repeat (3) @(negedge clk);

    // 3: y already high -> stuck, done two cycles after start asserted
    probe_y = 1'b1;
    repeat (3) @(negedge clk);
    p0    = px_cnt;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done("stk", 10, n);
    check("stk_done_cyc", n + 1, 32'd2);
    check("stk_stuck", 32'(stuck), 32'd1);
    check("stk_ok", 32'(ok), 32'd0);
    check("stk_timed_out", 32'(timed_out), 32'd0);
    check("stk_px_cycles", px_cnt - p0, 32'd0);
    probe_y = 1'b0;
    repeat (3) @(negedge clk);

    // 4: y reaches the FSM exactly when the counter hits 200 -> y wins
    start = 1'b1;
    @(negedge clk); start = 1'b0;                 // n0
    repeat (199) @(negedge clk);                  // n199
    probe_y = 1'b1;
    wait_done("tie", 10, n);
    check("tie_done_cyc", n, 32'd3);
    check("tie_ok", 32'(ok), 32'd1);
    check("tie_timed_out", 32'(timed_out), 32'd0);
    check("tie_latency", 32'(latency), 32'd200);
    probe_y = 1'b0;
    repeat (4) @(negedge clk);

    // 5: reset during PULSE clears outputs with no clock edge
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    check("rmid_px_before", 32'(probe_x), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rmid_probe_x", 32'(probe_x), 32'd0);
    check("rmid_busy", 32'(busy), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    fast_probe("post_rst");

    // 6: start held across two probes, extra pulse during WAIT ignored
    d0    = done_cnt;
    start = 1'b1;
    @(negedge clk);
    wait_done("b2b_1", 400, n);
    repeat (2) @(negedge clk);                    // relaunch sampled 2 edges after done
    check("b2b_relaunch", 32'(busy), 32'd1);
    start = 1'b0;
    repeat (100) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done("b2b_2", 400, n);
    repeat (10) @(negedge clk);
    check("b2b_idle", 32'(busy), 32'd0);
    check("b2b_done_pulses", done_cnt - d0, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
